// File: rtl/muldiv_if.sv
// muldiv_if: operation request, HI/LO move strobes and result bus of the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             HiWrite;
   logic             LoWrite;
   logic [WIDTH-1:0] WriteData;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic             Busy;
   logic             Done;
   logic             DivZero;
   modport master (output Start, Op, SrcA, SrcB, HiWrite, LoWrite, WriteData,
                   input Hi, Lo, Busy, Done, DivZero);
   modport slave (input Start, Op, SrcA, SrcB, HiWrite, LoWrite, WriteData,
                  output Hi, Lo, Busy, Done, DivZero);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step MIPS-style multiply/divide with HI/LO registers.
module muldiv_unit #(parameter int WIDTH = 32) (
   input logic      clk,
   input logic      rst_n,
   muldiv_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nx;
   logic [1:0] op;
   logic [WIDTH-1:0] m, r, q, hi, lo, abs_a, abs_b, hi_res, lo_res;
   logic [4:0] cnt;
   logic neg_q, neg_r, dz, done, div_zero, sa, sb;
   logic [WIDTH:0] sum, shl;
   logic [2*WIDTH-1:0] prod;
   always_comb begin
      sa = ~bus.Op[0] & bus.SrcA[WIDTH-1];
      sb = ~bus.Op[0] & bus.SrcB[WIDTH-1];
      abs_a = sa ? -bus.SrcA : bus.SrcA;
      abs_b = sb ? -bus.SrcB : bus.SrcB;
      sum = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
      shl = {r, q[WIDTH-1]};
      prod = neg_q ? -{r, q} : {r, q};
      hi_res = op[1] ? (neg_r ? -r : r) : prod[2*WIDTH-1:WIDTH];
      // A zero divisor leaves the dividend in r, so only LO needs forcing
      lo_res = op[1] ? (dz ? '1 : (neg_q ? -q : q)) : prod[WIDTH-1:0];
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = bus.Start ? RUN : IDLE;
         RUN: state_nx = (cnt == 5'd31) ? FIX : RUN;
         default: state_nx = IDLE;
      endcase
      bus.Busy = state != IDLE;
      bus.Hi = hi;
      bus.Lo = lo;
      bus.Done = done;
      bus.DivZero = div_zero;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op <= '0;
         m <= '0;
         r <= '0;
         q <= '0;
         cnt <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz <= 1'b0;
         hi <= '0;
         lo <= '0;
         done <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= state == FIX;
         div_zero <= state == FIX && dz;
         if (state == IDLE) begin
            if (bus.HiWrite) hi <= bus.WriteData;
            if (bus.LoWrite) lo <= bus.WriteData;
            if (bus.Start) begin
               op <= bus.Op;
               q <= abs_a;
               m <= abs_b;
               r <= '0;
               cnt <= '0;
               neg_q <= sa ^ sb;
               neg_r <= sa & bus.Op[1];
               dz <= bus.Op[1] && bus.SrcB == '0;
            end
         end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            if (!op[1]) begin
               r <= sum[WIDTH:1];
               q <= {sum[0], q[WIDTH-1:1]};
            end else if (shl >= {1'b0, m}) begin
               r <= shl[WIDTH-1:0] - m;
               q <= {q[WIDTH-2:0], 1'b1};
            end else begin
               r <= shl[WIDTH-1:0];
               q <= {q[WIDTH-2:0], 1'b0};
            end
         end else if (state == FIX) begin
            hi <= hi_res;
            lo <= lo_res;
         end
      end
endmodule
